// File: rtl/exp_add_seq.sv
// Exponent-path sequencer for FADD/FSUB/DADD/DSUB: load, compare/swap, chunked
// alignment shift, wait for the mantissa adder, normalize, overflow/underflow check.
module exp_add_seq #(
    parameter int CHUNK  = 8,
    parameter int SP_LIM = 26,
    parameter int DP_LIM = 55
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        fpuhold,
    input  logic        start,
    input  logic        dprec,
    input  logic        ae_small,
    input  logic        expsame,
    input  logic [15:0] exp_diff,
    input  logic        mant_rdy,
    input  logic [15:0] res_exp,
    output logic        busy,
    output logic        cyc0_rdy,
    output logic [1:0]  aexp_sel,
    output logic [1:0]  bexp_sel,
    output logic        swap,
    output logic        shift_vld,
    output logic [5:0]  shift_amt,
    output logic        norm_en,
    output logic        done,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [2:0] {
        IDLE, LOAD, CMP, SWAP, ALIGN, WAIT, NORM, CHK
    } state_t;

    localparam logic [5:0] CHUNK_6  = 6'(CHUNK);
    localparam logic [5:0] SP_LIM_6 = 6'(SP_LIM);
    localparam logic [5:0] DP_LIM_6 = 6'(DP_LIM);

    state_t      state;
    logic [5:0]  rem;
    logic        prec;

    logic [5:0]  lim;
    logic [5:0]  clamp;
    logic [5:0]  step_src;
    logic [5:0]  step_amt;
    logic [5:0]  step_left;
    logic        ovf_nxt;
    logic        unf_nxt;

    // Alignment distance is clamped to what the mantissa width can absorb; in CMP
    // the first step is cut straight from the clamped difference.
    always_comb begin
        lim = prec ? DP_LIM_6 : SP_LIM_6;
        if ((|exp_diff[15:6]) || (exp_diff[5:0] > lim)) begin
            clamp = lim;
        end else begin
            clamp = exp_diff[5:0];
        end
        step_src  = (state == CMP) ? clamp : rem;
        step_amt  = (step_src > CHUNK_6) ? CHUNK_6 : step_src;
        step_left = step_src - step_amt;
        unf_nxt   = res_exp[15] | (res_exp == 16'h0000);
        ovf_nxt   = !res_exp[15] && (res_exp >= (prec ? 16'h07ff : 16'h00ff));
    end

    // NOTE: every register in the FSM, outputs included, is assigned with <= so all
    // of them update together from the values present before the edge; the outputs
    // are loaded for the state being entered, which keeps them glitch-free.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            rem       <= '0;
            prec      <= 1'b0;
            busy      <= 1'b0;
            cyc0_rdy  <= 1'b0;
            aexp_sel  <= 2'b00;
            bexp_sel  <= 2'b00;
            swap      <= 1'b0;
            shift_vld <= 1'b0;
            shift_amt <= '0;
            norm_en   <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (!fpuhold) begin
            cyc0_rdy  <= 1'b0;
            aexp_sel  <= 2'b00;
            bexp_sel  <= 2'b00;
            swap      <= 1'b0;
            shift_vld <= 1'b0;
            shift_amt <= '0;
            norm_en   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        prec     <= dprec;
                        busy     <= 1'b1;
                        cyc0_rdy <= 1'b1;
                        aexp_sel <= dprec ? 2'b10 : 2'b01;
                        bexp_sel <= dprec ? 2'b10 : 2'b01;
                    end
                end
                LOAD: state <= CMP;
                CMP: begin
                    if (ae_small) begin
                        state <= SWAP;
                        swap  <= 1'b1;
                        rem   <= clamp;
                    end else if (expsame || (clamp == '0)) begin
                        state <= WAIT;
                        rem   <= '0;
                    end else begin
                        state     <= ALIGN;
                        shift_vld <= 1'b1;
                        shift_amt <= step_amt;
                        rem       <= step_left;
                    end
                end
                SWAP, ALIGN: begin
                    if (rem == '0) begin
                        state <= WAIT;
                    end else begin
                        state     <= ALIGN;
                        shift_vld <= 1'b1;
                        shift_amt <= step_amt;
                        rem       <= step_left;
                    end
                end
                WAIT: begin
                    if (mant_rdy) begin
                        state   <= NORM;
                        norm_en <= 1'b1;
                    end
                end
                NORM: begin
                    // Flags sample the normalized exponent and then hold until the next op.
                    state <= CHK;
                    done  <= 1'b1;
                    ovf   <= ovf_nxt;
                    unf   <= unf_nxt;
                end
                CHK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_add_seq.sv
// Directed bench for exp_add_seq: table of whole-operation vectors plus
// hand-written hold, mid-op reset and restart sequences.
module tb_exp_add_seq;

    logic        clk;
    logic        reset_l;
    logic        fpuhold;
    logic        start;
    logic        dprec;
    logic        ae_small;
    logic        expsame;
    logic [15:0] exp_diff;
    logic        mant_rdy;
    logic [15:0] res_exp;
    logic        busy;
    logic        cyc0_rdy;
    logic [1:0]  aexp_sel;
    logic [1:0]  bexp_sel;
    logic        swap;
    logic        shift_vld;
    logic [5:0]  shift_amt;
    logic        norm_en;
    logic        done;
    logic        ovf;
    logic        unf;
    logic [17:0] outs;

    int checks   = 0;
    int failures = 0;

    exp_add_seq dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .fpuhold   (fpuhold),
        .start     (start),
        .dprec     (dprec),
        .ae_small  (ae_small),
        .expsame   (expsame),
        .exp_diff  (exp_diff),
        .mant_rdy  (mant_rdy),
        .res_exp   (res_exp),
        .busy      (busy),
        .cyc0_rdy  (cyc0_rdy),
        .aexp_sel  (aexp_sel),
        .bexp_sel  (bexp_sel),
        .swap      (swap),
        .shift_vld (shift_vld),
        .shift_amt (shift_amt),
        .norm_en   (norm_en),
        .done      (done),
        .ovf       (ovf),
        .unf       (unf)
    );

    assign outs = {busy, cyc0_rdy, aexp_sel, bexp_sel, swap, shift_vld,
                   shift_amt, norm_en, done, ovf, unf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          dprec;
        bit          ae_small;
        bit          expsame;
        bit          restart;
        logic [15:0] exp_diff;
        logic [15:0] res_exp;
        int          mant_cyc;
        int          done_cyc;
        int          n_steps;
        int          sum;
        int          first;
        int          last;
        int          swaps;
        bit          ovf;
        bit          unf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Cycle k starts at posedge k; outputs are sampled and inputs driven 1 time unit later.
    task automatic run_op(input vec_t v, input int idx);
        int done_cyc = 0;
        int done_cnt = 0;
        int n_steps  = 0;
        int sum      = 0;
        int first    = 0;
        int last     = 0;
        int swaps    = 0;
        int c0       = 0;
        int sel_a    = 0;
        int sel_b    = 0;
        int f_ovf    = 0;
        int f_unf    = 0;
        int k        = 0;
        bit run      = 1'b1;
        // NOTE: bench inputs are driven with blocking assignments away from the clock
        // edge, so the DUT always samples settled values.
        start    = 1'b1;
        dprec    = v.dprec;
        ae_small = v.ae_small;
        expsame  = v.expsame;
        exp_diff = v.exp_diff;
        res_exp  = v.res_exp;
        mant_rdy = (v.mant_cyc <= 0);
        while (run) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                c0    = int'(cyc0_rdy);
                sel_a = int'(aexp_sel);
                sel_b = int'(bexp_sel);
            end
            if (shift_vld) begin
                if (n_steps == 0) first = int'(shift_amt);
                last = int'(shift_amt);
                sum += int'(shift_amt);
                n_steps++;
            end
            if (swap) swaps++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    f_ovf    = int'(ovf);
                    f_unf    = int'(unf);
                end
            end
            start    = v.restart && (k >= 2) && (k <= 4);
            mant_rdy = (k >= v.mant_cyc);
            if ((done_cyc != 0 && k >= done_cyc + 3) || k >= 40) run = 1'b0;
        end
        start    = 1'b0;
        mant_rdy = 1'b0;
        check($sformatf("v%0d_done_cyc", idx), done_cyc, v.done_cyc);
        check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
        check($sformatf("v%0d_n_steps", idx), n_steps, v.n_steps);
        check($sformatf("v%0d_shift_sum", idx), sum, v.sum);
        check($sformatf("v%0d_first_step", idx), first, v.first);
        check($sformatf("v%0d_last_step", idx), last, v.last);
        check($sformatf("v%0d_swaps", idx), swaps, v.swaps);
        check($sformatf("v%0d_ovf", idx), f_ovf, int'(v.ovf));
        check($sformatf("v%0d_unf", idx), f_unf, int'(v.unf));
        check($sformatf("v%0d_cyc0_rdy", idx), c0, 1);
        check($sformatf("v%0d_aexp_sel", idx), sel_a, v.dprec ? 2 : 1);
        check($sformatf("v%0d_bexp_sel", idx), sel_b, v.dprec ? 2 : 1);
        check($sformatf("v%0d_busy_end", idx), int'(busy), 0);
    endtask

    initial begin
        int hold_cyc[15];
        int exp_vld[15];
        int exp_amt[15];
        int exp_done[15];
        int cnt;

        //          dp as es rs diff      res       mc  done st sum 1st last sw ovf unf
        vecs[0] = '{0, 0, 0, 0, 16'd20,   16'h0080, 6,  8,   3, 20, 8, 4,  0, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 16'd100,  16'h07ff, 1,  13,  7, 55, 8, 7,  1, 1, 0};
        vecs[2] = '{0, 0, 1, 0, 16'd0,    16'hfffe, 7,  9,   0, 0,  0, 0,  0, 0, 1};
        vecs[3] = '{1, 0, 0, 1, 16'd16,   16'h07fe, 5,  7,   2, 16, 8, 8,  0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 16'd3,    16'h0000, 4,  6,   1, 3,  3, 3,  0, 0, 1};
        vecs[5] = '{1, 0, 0, 0, 16'd60,   16'h00ff, 0,  12,  7, 55, 8, 7,  0, 0, 0};
        vecs[6] = '{0, 1, 0, 0, 16'd5,    16'h00fe, 0,  7,   1, 5,  5, 5,  1, 0, 0};
        vecs[7] = '{0, 0, 0, 0, 16'd1000, 16'h00ff, 0,  9,   4, 26, 8, 2,  0, 1, 0};

        reset_l  = 1'b0;
        fpuhold  = 1'b0;
        start    = 1'b0;
        dprec    = 1'b0;
        ae_small = 1'b0;
        expsame  = 1'b0;
        exp_diff = '0;
        mant_rdy = 1'b0;
        res_exp  = '0;
        #2;
        check("reset_outputs", int'(outs), 0);
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // Abort in WAIT: the last vector left ovf=1, which reset must also clear.
        start    = 1'b1;
        dprec    = 1'b0;
        ae_small = 1'b0;
        expsame  = 1'b1;
        exp_diff = '0;
        res_exp  = 16'h0080;
        mant_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 3) check("rst_busy_in_wait", int'(busy), 1);
        end
        reset_l = 1'b0;
        #1;
        check("rst_async_outputs", int'(outs), 0);
        #2;
        reset_l  = 1'b1;
        mant_rdy = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        mant_rdy = 1'b0;
        check("rst_no_done", cnt, 0);
        check("rst_idle_busy", int'(busy), 0);

        // Stall for three edges after the first 8-step (rem=12), then again on done.
        for (int k = 0; k < 15; k++) begin
            hold_cyc[k] = 0;
            exp_vld[k]  = 0;
            exp_amt[k]  = 0;
            exp_done[k] = 0;
        end
        for (int k = 3; k <= 7; k++) begin
            exp_vld[k] = 1;
            exp_amt[k] = 8;
        end
        exp_vld[8]  = 1;
        exp_amt[8]  = 4;
        exp_done[11] = 1;
        exp_done[12] = 1;
        exp_done[13] = 1;
        hold_cyc[3]  = 1;
        hold_cyc[4]  = 1;
        hold_cyc[5]  = 1;
        hold_cyc[11] = 1;
        hold_cyc[12] = 1;
        start    = 1'b1;
        dprec    = 1'b0;
        ae_small = 1'b0;
        expsame  = 1'b0;
        exp_diff = 16'd20;
        res_exp  = 16'h0080;
        mant_rdy = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("hold_vld_c%0d", k), int'(shift_vld), exp_vld[k]);
            check($sformatf("hold_amt_c%0d", k), int'(shift_amt), exp_amt[k]);
            check($sformatf("hold_done_c%0d", k), int'(done), exp_done[k]);
            fpuhold = (hold_cyc[k] != 0);
        end
        fpuhold  = 1'b0;
        mant_rdy = 1'b0;
        check("hold_busy_end", int'(busy), 0);

        run_op(vecs[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_add_seq.md
Name: exp_add_seq

Overview:
- Sequencer for the FPU exponent datapath during FADD/FSUB/DADD/DSUB.
- Loads the operand exponents and compares them to decide the swap.
- Issues the clamped alignment shift in chunked steps, waits for the mantissa adder, then steers normalization and checks the result for overflow and underflow.
- Sits between the microcode ROM dispatch (start) and the exponent/mantissa datapaths; owns their add-path selects while busy.

Parameters:
- CHUNK, 8, maximum alignment shift issued per cycle.
- SP_LIM, 26, single-precision alignment shift clamp.
- DP_LIM, 55, double-precision alignment shift clamp.

Ports:
- clk  in  1  clock
- reset_l  in  1  asynchronous reset, active low
- fpuhold  in  1  stall; freezes all state
- start  in  1  one-cycle op request; sampled only in IDLE
- dprec  in  1  double precision; sampled with start
- ae_small  in  1  sign of (aexp - bexp)
- expsame  in  1  aexp == bexp
- exp_diff  in  16  |aexp - bexp| from datapath
- mant_rdy  in  1  mantissa add complete
- res_exp  in  16  exponent after normalization, two's complement
- busy  out  1  op in progress
- cyc0_rdy  out  1  operand-load cycle
- aexp_sel  out  2  00 hold/next, 01 load 8-bit, 10 load 11-bit
- bexp_sel  out  2  same encoding as aexp_sel
- swap  out  1  exchange operands (one-cycle pulse)
- shift_vld  out  1  alignment shift step valid
- shift_amt  out  6  shift this step
- norm_en  out  1  select leading-zero-adjusted exponent
- done  out  1  one-cycle completion pulse
- ovf  out  1  overflow flag, valid with done
- unf  out  1  underflow flag, valid with done

Behaviour:
- Reset (async, reset_l=0): state=IDLE; all outputs 0; rem=0; prec=0.
- fpuhold=1: state, rem, prec and all outputs hold their current values. A pending done or swap pulse stays asserted until the hold is released and then lasts exactly one unheld cycle.
- States: IDLE, LOAD, CMP, SWAP, ALIGN, WAIT, NORM, CHK.
- IDLE:
  - busy=0.
  - start=1 -> latch prec=dprec -> LOAD.
- LOAD:
  - cyc0_rdy=1.
  - aexp_sel=bexp_sel = prec ? 10 : 01.
  - -> CMP.
- CMP:
  - rem = min(exp_diff, prec ? DP_LIM : SP_LIM). Any exp_diff[15:6] nonzero counts as over the limit.
  - ae_small=1 -> SWAP.
  - else expsame=1 -> WAIT (no alignment).
  - else -> ALIGN.
- SWAP: swap=1 for one cycle; -> ALIGN.
- ALIGN:
  - Each cycle: shift_vld=1, shift_amt=min(rem, CHUNK), rem -= shift_amt.
  - When the issued step makes rem 0 -> WAIT.
  - Steps per op = ceil(rem/CHUNK).
- WAIT:
  - Stay until mant_rdy=1, then -> NORM.
  - No timeout.
  - mant_rdy asserted before WAIT is ignored; mant_rdy must be high in WAIT.
- NORM: norm_en=1 for one cycle; -> CHK.
- CHK:
  - unf = res_exp[15] | (res_exp==0).
  - ovf = !res_exp[15] & (res_exp >= (prec ? 16'h7ff : 16'hff)).
  - ovf and unf are mutually exclusive.
  - done=1; -> IDLE.
- busy=1 in every state except IDLE. Latency with no stalls: 5 cycles + align steps + WAIT cycles from start to done.
- start while busy is ignored; no queueing.
- Flags hold their value until the next done.
- Reset asserted mid-operation aborts immediately; no done is issued.

Test Plan:
- SP, ae_small=0, expsame=0, exp_diff=20, mant_rdy at first WAIT cycle -> shift steps 8,8,4; swap never asserted; done 8 cycles after start; res_exp=16'h80 -> ovf=0, unf=0.
- DP, ae_small=1, exp_diff=100 -> swap pulse, rem clamped to 55, steps 8×6 then 7; res_exp=16'h7ff -> done with ovf=1.
- SP, expsame=1 -> no shift_vld; mant_rdy delayed 4 cycles -> done 4 cycles later; res_exp=16'hfffe -> unf=1.
- fpuhold=1 for 3 cycles in mid-ALIGN with rem=12 -> shift_amt held; after release, steps resume 8 then 4; total step count unchanged.
- reset_l low during WAIT -> busy=0 and all outputs 0 immediately, no done; a new start afterwards completes normally.
- start pulsed while busy -> ignored; exactly one done per accepted start.
